// File: rtl/dmem_port_model.sv
`default_nettype none
// ============================================================================
// dmem_port_model : valid/ready data-memory responder, in-order fixed-latency
//                   loads, bounded outstanding loads, HTIF tohost detection.
//                   Optional macro DMEM_RANDOM_STALL_EN adds LFSR req_ready stalls.
// Revision        : 1.0
// ============================================================================
module dmem_port_model #(
  parameter int unsigned MEM_SIZE_WORDS = 16384,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned MAX_INFLIGHT   = 2,
  parameter logic [31:0] TOHOST_ADDR    = 32'h00001000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        addr_err,
  output logic [3:0]  inflight
);

  localparam int unsigned C_AW       = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
  localparam logic [31:0] C_BAD_DATA = 32'hDEADBEEF;

  logic [31:0] mem [MEM_SIZE_WORDS];

  logic [29:0] idx;
  logic        in_range;
  logic        is_tohost;
  logic        stall;
  logic        accept;
  logic        acc_load;
  logic        acc_store;
  logic        acc_tohost;
  logic [31:0] rd_data;

  logic [3:0]  inflight_q, inflight_d;
  logic        addr_err_q, addr_err_d;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;
  logic [LATENCY-1:0] dl_valid_q, dl_valid_d;
  logic [31:0] dl_data_q [LATENCY];
  logic [31:0] dl_data_d [LATENCY];

  assign idx       = req_addr[31:2];
  assign in_range  = {2'b00, idx} < MEM_SIZE_WORDS;
  assign is_tohost = (req_addr == TOHOST_ADDR);

`ifdef DMEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 shifted toward the MSB
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Ready depends only on registered state so it never loops through req_valid
  assign req_ready  = (inflight_q < 4'(MAX_INFLIGHT)) && !stall;
  assign accept     = req_valid && req_ready;
  assign acc_load   = accept && !req_we;
  assign acc_store  = accept && req_we;
  assign acc_tohost = acc_store && is_tohost;
  assign rd_data    = in_range ? mem[idx[C_AW-1:0]] : C_BAD_DATA;

  always_comb begin
    dl_valid_d    = dl_valid_q;
    dl_data_d     = dl_data_q;
    dl_valid_d[0] = acc_load;
    dl_data_d[0]  = acc_load ? rd_data : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_data_d[i]  = dl_data_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (acc_load && !resp_valid) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!acc_load && resp_valid) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  always_comb begin
    addr_err_d     = addr_err_q || (accept && !in_range);
    tohost_valid_d = acc_tohost;
    tohost_data_d  = acc_tohost ? req_data : tohost_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q     <= 4'd0;
      addr_err_q     <= 1'b0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
      dl_valid_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_data_q[i] <= 32'h0;
      end
    end else begin
      inflight_q     <= inflight_d;
      addr_err_q     <= addr_err_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
      dl_valid_q     <= dl_valid_d;
      dl_data_q      <= dl_data_d;
    end
  end

  // Backing store survives reset; tohost and out-of-range stores never land
  always_ff @(posedge clk) begin
    if (acc_store && in_range && !is_tohost) begin
      mem[idx[C_AW-1:0]] <= req_data;
    end
  end

  assign resp_valid   = dl_valid_q[LATENCY-1];
  assign resp_data    = dl_data_q[LATENCY-1];
  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
  assign addr_err     = addr_err_q;
  assign inflight     = inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_model.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_model : table-driven and random checks of dmem_port_model
//                      against a cycle-level transaction model.
// Revision           : 1.0
// ============================================================================
module tb_dmem_port_model;

  localparam int LAT  = 2;
  localparam int MAXI = 3;
  localparam int MSZ  = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = 32'h0, req_data = 32'h0;
  logic        req_ready, resp_valid, tohost_valid, addr_err;
  logic [31:0] resp_data, tohost_data;
  logic [3:0]  inflight;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [31:0] b_req_addr = 32'h0, b_req_data = 32'h0;
  logic        b_req_ready, b_resp_valid, b_tohost_valid, b_addr_err;
  logic [31:0] b_resp_data, b_tohost_data;
  logic [3:0]  b_inflight;

  dmem_port_model #(.MEM_SIZE_WORDS(MSZ), .LATENCY(LAT), .MAX_INFLIGHT(MAXI),
                    .TOHOST_ADDR(32'h00001000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .tohost_valid(tohost_valid),
    .tohost_data(tohost_data), .addr_err(addr_err), .inflight(inflight));

  dmem_port_model #(.MEM_SIZE_WORDS(1024), .LATENCY(2), .MAX_INFLIGHT(1),
                    .TOHOST_ADDR(32'h00001000)) dut1 (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_data(b_req_data),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .tohost_valid(b_tohost_valid),
    .tohost_data(b_tohost_data), .addr_err(b_addr_err), .inflight(b_inflight));

  always #5 clk = ~clk;

  typedef struct { int e0; logic [31:0] data; } pend_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] want; } vec_t;

  pend_t       q[$];
  logic [31:0] mmem [MSZ];
  int          cyc = 0, tests = 0, fails = 0, resp_cnt = 0, rdy_low = 0, infl_exp = 0;
  logic        exp_thv = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_thd = 32'h0, last_resp = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // One clock of the main port: drive at negedge, model the edge, check at next negedge
  task automatic cycle(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic exp_rdy, inr, exp_rv;
    exp_rdy = (infl_exp < MAXI);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!req_ready) rdy_low++;
    req_valid = v; req_we = we; req_addr = a; req_data = d;
    @(posedge clk);
    cyc++;
    exp_thv = 1'b0;
    if (v && exp_rdy) begin
      inr = (a[31:2] < 30'(MSZ));
      if (!inr) exp_err = 1'b1;
      if (we) begin
        if (a == 32'h00001000) begin
          exp_thv = 1'b1;
          exp_thd = d;
        end else if (inr) begin
          mmem[a[15:2]] = d;
        end
      end else begin
        q.push_back('{e0: cyc, data: inr ? mmem[a[15:2]] : 32'hDEADBEEF});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    infl_exp = q.size();
    exp_rv = (q.size() > 0) && (q[0].e0 + LAT - 1 == cyc);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (resp_valid) begin
      last_resp = resp_data;
      resp_cnt++;
    end
    if (exp_rv) begin
      chk("resp_data", resp_data, q[0].data);
      void'(q.pop_front());
    end
    chk("inflight", 32'(inflight), 32'(infl_exp));
    chk("tohost_valid", 32'(tohost_valid), 32'(exp_thv));
    chk("tohost_data", tohost_data, exp_thd);
    chk("addr_err", 32'(addr_err), 32'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    exp_thv = 1'b0; exp_thd = 32'h0; exp_err = 1'b0; infl_exp = 0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("rst_tohost_data", tohost_data, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    vec_t vt[8];
    int   r0, acc, bresp, bad;
    logic rdy;

    vt[0] = '{1'b1, 32'h00000100, 32'hCAFEF00D, 32'h0};
    vt[1] = '{1'b0, 32'h00000100, 32'h0,        32'hCAFEF00D};
    vt[2] = '{1'b1, 32'h00001000, 32'h00000001, 32'h0};
    vt[3] = '{1'b0, 32'h00001000, 32'h0,        32'h0BADF00D};
    vt[4] = '{1'b1, 32'h00000204, 32'h11112222, 32'h0};
    vt[5] = '{1'b0, 32'h00000207, 32'h0,        32'h11112222};
    vt[6] = '{1'b0, 32'h00100000, 32'h0,        32'hDEADBEEF};
    vt[7] = '{1'b1, 32'h00100000, 32'h55555555, 32'h0};

    @(negedge clk);
    do_reset();
    dut.mem[1024] = 32'h0BADF00D;
    mmem[1024]    = 32'h0BADF00D;

    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 32'(i * 4), $urandom);

    foreach (vt[i]) begin
      last_resp = 32'h0;
      cycle(1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
      if (vt[i].we && vt[i].addr == 32'h00001000) begin
        chk("tab_tohost_pulse", 32'(tohost_valid), 32'd1);
        chk("tab_tohost_data", tohost_data, vt[i].wdata);
      end
      for (int k = 0; k < LAT; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
      if (!vt[i].we) chk("tab_load_data", last_resp, vt[i].want);
    end
    chk("addr_err_set", 32'(addr_err), 32'd1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("addr_err_sticky", 32'(addr_err), 32'd1);

    r0 = resp_cnt; rdy_low = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(i * 4), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_resp_count", 32'(resp_cnt - r0), 32'd5);
    chk("b2b_ready_low", 32'(rdy_low), 32'd0);

    // MAX_INFLIGHT=1 instance: one store, then a continuous load request
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h0; b_req_data = 32'h5A5A0001;
    chk("max1_ready_idle", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_req_we = 1'b0;
    acc = 0; bresp = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = b_req_ready;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
      if (b_inflight > 4'd1) bad++;
      if (b_req_ready && b_inflight != 4'd0) bad++;
      if (b_resp_valid) begin
        bresp++;
        if (b_resp_data != 32'h5A5A0001) bad++;
      end
    end
    b_req_valid = 1'b0;
    chk("max1_accepts", 32'(acc), 32'd4);
    chk("max1_responses", 32'(bresp), 32'd4);
    chk("max1_violations", 32'(bad), 32'd0);

    cycle(1'b1, 1'b0, 32'h00000100, 32'h0);
    cycle(1'b1, 1'b0, 32'h00000000, 32'h0);
    do_reset();
    r0 = resp_cnt;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_no_resp", 32'(resp_cnt - r0), 32'd0);
    last_resp = 32'h0;
    cycle(1'b1, 1'b0, 32'h00000100, 32'h0);
    for (int k = 0; k < LAT; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_mem_kept", last_resp, 32'hCAFEF00D);

    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 99));
      if (sel < 5)       a = 32'h00001000;
      else if (sel < 10) a = 32'h00010000 | $urandom;
      else               a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), a, $urandom);
    end
    for (int k = 0; k < LAT + 1; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_model.md
# dmem_port_model

Behavioural data-memory responder that sits directly downstream of the CPU core's data-memory port in the CPU testbench. It accepts load/store requests over a valid/ready handshake and returns load data in order after a fixed latency. It bounds outstanding loads and detects stores to the HTIF tohost address. It replaces the always-ready, 1-cycle data path so the core's backpressure and latency tolerance can be exercised.

## Interface
- MEM_SIZE_WORDS, 16384: backing-store depth in 32-bit words (word-addressed, base 0).
- LATENCY, 2: load latency in clock edges, legal range 1..8.
- MAX_INFLIGHT, 2: maximum loads accepted but not yet responded, legal range 1..LATENCY+1.
- TOHOST_ADDR, 32'h00001000: HTIF tohost byte address.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_data  input  32  store data.
- resp_valid  output  1  one-cycle pulse carrying load data.
- resp_data  output  32  load data, valid only with resp_valid.
- tohost_valid  output  1  one-cycle pulse on a tohost store.
- tohost_data  output  32  last value stored to tohost; held.
- addr_err  output  1  sticky flag for an out-of-range access.
- inflight  output  4  current outstanding-load count.

## Operation
- A request is accepted on an edge where req_valid && req_ready. At most one request is accepted per cycle.
- Word index: idx = req_addr[31:2]. The address is out of range when idx >= MEM_SIZE_WORDS.
- Store, in range, address != TOHOST_ADDR:
  - mem[idx] is written at the accepting edge.
  - No response is generated.
- Store to TOHOST_ADDR:
  - Memory is not written.
  - tohost_data <= req_data.
  - tohost_valid pulses in the following cycle.
- Load:
  - mem[idx] is sampled at the accepting edge into a LATENCY-stage delay line of {valid, data}.
  - An out-of-range load returns 32'hDEADBEEF.
  - A store accepted before the load is visible to it. A store accepted after the load is not.
- Out-of-range store: the write is dropped.
- Any out-of-range access sets addr_err. It clears only on reset.
- inflight:
  - +1 on each accepted load.
  - −1 on each edge where resp_valid is high.
  - Unchanged when both happen on the same edge.
  - Never exceeds MAX_INFLIGHT and never underflows.
- req_ready = (inflight < MAX_INFLIGHT), gated by the stall injector when configured. req_ready is combinational from registers only, never from req_valid.
- Responses are strictly in acceptance order. There is no response backpressure.
- Memory contents are not initialised by reset. The bench loads them through a hierarchical path or `$readmemh`.

## Timing
- Label the accepting edge E0. resp_valid rises after edge E0+LATENCY−1 and falls after edge E0+LATENCY. The response is therefore observed at edge E0+LATENCY, and LATENCY=1 gives a response on the next edge.
- Back-to-back loads with MAX_INFLIGHT ≥ LATENCY+1 sustain one response per cycle.
- With MAX_INFLIGHT=1, req_ready is low from the cycle after a load is accepted until the cycle after its resp_valid. When resp_valid is high, inflight returns to 0 on that edge, so req_ready is high in the following cycle.
- tohost_valid goes high in the cycle after the accepting edge, for one cycle.
- Reset values: req_ready=1 (0 if the stall injector blocks), resp_valid=0, resp_data=0, tohost_valid=0, tohost_data=0, addr_err=0, inflight=0, delay line cleared.
- Reset asserted mid-operation discards all pending responses; none are emitted after release. Memory contents are retained.

## Configuration
- DMEM_RANDOM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is reset to 16'hACE1 and advances every cycle.
  - req_ready is additionally forced low whenever lfsr[1:0]==2'b00.
  - All other behaviour is unchanged.
- DMEM_RANDOM_STALL_EN undefined: no LFSR exists, and req_ready depends only on inflight.

## Test plan
- Store 32'hCAFEF00D to 0x100, then load 0x100 (LATENCY=2) -> resp_valid is a single pulse at edge E0+2 with resp_data=32'hCAFEF00D, and inflight returns to 0.
- Five back-to-back loads of 0x0,0x4,…,0x10 with LATENCY=2 and MAX_INFLIGHT=3 -> five consecutive resp_valid cycles, data in order, req_ready never low.
- MAX_INFLIGHT=1 with continuous load requests -> req_ready alternates, each load waits for the previous response, inflight ≤ 1.
- Store 32'h1 to 0x1000 -> tohost_valid pulses once, tohost_data=32'h1, mem[0x400] unchanged.
- Load 0x00100000 with MEM_SIZE_WORDS=16384 -> resp_data=32'hDEADBEEF and addr_err=1, still set 100 cycles later.
- Two loads in flight, then reset asserted for 1 cycle -> no resp_valid after release, inflight=0, earlier stores still readable.
